// File: rtl/cpu_clk_enable_ctrl_pkg.sv
// Shared definitions for the processor clock-enable controller:
// mode encodings and the default debounce length.
package clk_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_NORMAL = 2'b00,
        MODE_DEBUG  = 2'b01,
        MODE_STEP   = 2'b10
    } mode_t;

    // 20 ms of stable input at 50 MHz
    localparam int DEBOUNCE_CYCLES_DEFAULT = 1_000_000;

endpackage

// File: rtl/cpu_clk_enable_ctrl_key_debounce.sv
// Pushbutton conditioner: 2-flop synchroniser, stability counter and a
// single-cycle press pulse on each accepted released->pressed change.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int DB_CNT_W        = 20
) (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic key_n,
    output logic press
);

    localparam logic [DB_CNT_W-1:0] CNT_MAX = DB_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic                sync1;
    logic                sync2;
    logic                stable;
    logic [DB_CNT_W-1:0] cnt;
    logic                accept;

    // The stable value is about to take the synchronised value this cycle
    assign accept = (sync2 != stable) && (cnt == CNT_MAX);
    // Only the 1->0 (released->pressed) acceptance produces a pulse
    assign press  = accept & stable;

    // Bring the asynchronous key into the CLOCK_50 domain
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
        end
    end

    // Accept a new level only after it has held for DEBOUNCE_CYCLES cycles
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            stable <= 1'b1;
            cnt    <= '0;
        end else if (sync2 == stable) begin
            cnt    <= '0;
        end else if (cnt == CNT_MAX) begin
            stable <= sync2;
            cnt    <= '0;
        end else begin
            cnt    <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/cpu_clk_enable_ctrl.sv
// Processor clock-enable generator. Converts divider taps and two board
// pushbuttons into a single-cycle cpu_ce in NORMAL, DEBUG or STEP mode,
// all in the CLOCK_50 domain.
module cpu_clk_enable_ctrl
    import clk_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int DB_CNT_W        = 20,
    parameter int STEP_CNT_W      = 8
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    input  logic                  divclock,
    input  logic                  depclock,
    input  logic                  KEY_mode,
    input  logic                  KEY_step,
    output logic                  cpu_ce,
    output logic [1:0]            mode,
    output logic [STEP_CNT_W-1:0] step_count
);

    mode_t mode_q;
    logic  prev_div;
    logic  prev_dep;
    logic  rise_div;
    logic  rise_dep;
    logic  mode_press;
    logic  step_press;

    key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .DB_CNT_W        (DB_CNT_W)
    ) u_db_mode (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .key_n    (KEY_mode),
        .press    (mode_press)
    );

    key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .DB_CNT_W        (DB_CNT_W)
    ) u_db_step (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .key_n    (KEY_step),
        .press    (step_press)
    );

    assign rise_div = divclock & ~prev_div;
    assign rise_dep = depclock & ~prev_dep;
    assign mode     = mode_q;

    // Tap history for rising-edge detection
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            prev_div <= 1'b0;
            prev_dep <= 1'b0;
        end else begin
            prev_div <= divclock;
            prev_dep <= depclock;
        end
    end

    // Mode FSM and cpu_ce register: pulse source follows the current (old) mode
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            mode_q <= MODE_NORMAL;
            cpu_ce <= 1'b0;
        end else begin
            case (mode_q)
                MODE_NORMAL: begin
                    cpu_ce <= rise_div;
                    if (mode_press) mode_q <= MODE_DEBUG;
                end
                MODE_DEBUG: begin
                    cpu_ce <= rise_dep;
                    if (mode_press) mode_q <= MODE_STEP;
                end
                MODE_STEP: begin
                    cpu_ce <= step_press;
                    if (mode_press) mode_q <= MODE_NORMAL;
                end
                default: begin
                    // Unreachable 2'b11: recover to NORMAL silently
                    cpu_ce <= 1'b0;
                    mode_q <= MODE_NORMAL;
                end
            endcase
        end
    end

    // Count issued pulses; wraps naturally at 2^STEP_CNT_W
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            step_count <= '0;
        end else if (cpu_ce) begin
            step_count <= step_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_cpu_clk_enable_ctrl.sv
// Directed self-checking bench for cpu_clk_enable_ctrl (short debounce).
module tb_cpu_clk_enable_ctrl;

    localparam int DB = 8;

    logic       CLOCK_50 = 1'b0;
    logic       reset;
    logic       divclock;
    logic       depclock;
    logic       KEY_mode;
    logic       KEY_step;
    logic       cpu_ce;
    logic [1:0] mode;
    logic [7:0] step_count;

    int errors = 0;
    int checks = 0;
    int exp_sc = 0;

    cpu_clk_enable_ctrl #(
        .DEBOUNCE_CYCLES (DB),
        .DB_CNT_W        (20),
        .STEP_CNT_W      (8)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .divclock   (divclock),
        .depclock   (depclock),
        .KEY_mode   (KEY_mode),
        .KEY_step   (KEY_step),
        .cpu_ce     (cpu_ce),
        .mode       (mode),
        .step_count (step_count)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge
    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Hold a key low for 'hold' cycles, release, let release settle; count cpu_ce pulses
    task automatic press_key(input bit is_step, input int hold, output int pulses);
        pulses = 0;
        if (is_step) KEY_step = 1'b0; else KEY_mode = 1'b0;
        for (int i = 0; i < hold; i++) begin
            tick();
            if (cpu_ce) pulses++;
        end
        if (is_step) KEY_step = 1'b1; else KEY_mode = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (cpu_ce) pulses++;
        end
    endtask

    initial begin
        int n;
        int k;
        bit seen_ce;

        reset    = 1'b1;
        divclock = 1'b0;
        depclock = 1'b0;
        KEY_mode = 1'b1;
        KEY_step = 1'b1;

        // 1: reset for 2 cycles
        tick();
        tick();
        check("reset_ce", cpu_ce, 0);
        check("reset_mode", mode, 0);
        check("reset_cnt", step_count, 0);
        reset = 1'b0;
        seen_ce = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (cpu_ce || mode != 2'b00 || step_count != 8'd0) seen_ce = 1'b1;
        end
        check("post_reset_idle", seen_ce, 0);

        // 2: NORMAL, divclock period 64
        for (int p = 0; p < 4; p++) begin
            divclock = 1'b1;
            tick();
            check("normal_ce_latency", cpu_ce, 1);
            n = 1;
            exp_sc++;
            for (int i = 1; i < 64; i++) begin
                if (i == 32) divclock = 1'b0;
                tick();
                if (cpu_ce) n++;
            end
            check("normal_pulses_per_period", n, 1);
        end
        check("normal_step_count", step_count, exp_sc);

        // 3: short glitch ignored, long press advances mode after 2+8 cycles
        KEY_mode = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        KEY_mode = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        check("glitch_mode", mode, 0);

        KEY_mode = 1'b0;
        k = 0;
        while (mode == 2'b00 && k < 40) begin
            tick();
            k++;
        end
        check("mode_press_latency", k, 10);
        check("mode_debug", mode, 1);
        for (int i = k; i < 20; i++) tick();
        KEY_mode = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        check("mode_once", mode, 1);
        check("mode_keys_no_ce", step_count, exp_sc);

        // 4: DEBUG, only depclock rises produce pulses
        for (int r = 0; r < 3; r++) begin
            divclock = 1'b1;
            tick();
            check("debug_div_ignored", cpu_ce, 0);
            divclock = 1'b0;
            tick();
            depclock = 1'b1;
            tick();
            check("debug_dep_pulse", cpu_ce, 1);
            exp_sc++;
            tick();
            check("debug_dep_single", cpu_ce, 0);
            depclock = 1'b0;
            tick();
        end
        divclock = 1'b1;
        depclock = 1'b1;
        tick();
        check("debug_both_taps", cpu_ce, 1);
        exp_sc++;
        divclock = 1'b0;
        depclock = 1'b0;
        tick();
        check("debug_step_count", step_count, exp_sc);

        // 5: STEP mode
        press_key(1'b0, 30, n);
        check("to_step_mode", mode, 2);
        check("to_step_no_ce", n, 0);
        press_key(1'b1, 1000, n);
        check("step_long_hold", n, 1);
        exp_sc += n;
        n = 0;
        for (int j = 0; j < 3; j++) begin
            press_key(1'b1, 30, k);
            n += k;
        end
        check("step_three_presses", n, 3);
        exp_sc += n;
        n = 0;
        for (int j = 0; j < 3; j++) begin
            divclock = 1'b1;
            depclock = 1'b1;
            tick();
            if (cpu_ce) n++;
            divclock = 1'b0;
            depclock = 1'b0;
            tick();
            if (cpu_ce) n++;
        end
        check("step_taps_ignored", n, 0);
        check("step_count_step", step_count, exp_sc);
        press_key(1'b0, 30, n);
        check("back_to_normal", mode, 0);
        press_key(1'b1, 30, n);
        check("step_in_normal_ignored", n, 0);
        check("step_count_normal", step_count, exp_sc);

        // 6: wrap of step_count
        while (exp_sc < 255) begin
            divclock = 1'b1;
            tick();
            divclock = 1'b0;
            tick();
            exp_sc++;
        end
        check("count_ff", step_count, 255);
        divclock = 1'b1;
        tick();
        divclock = 1'b0;
        tick();
        check("count_wrap", step_count, 0);

        // Reset mid-operation in STEP with both keys mid-debounce
        press_key(1'b0, 30, n);
        press_key(1'b0, 30, n);
        check("step_again", mode, 2);
        KEY_step = 1'b0;
        KEY_mode = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        reset = 1'b1;
        seen_ce = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (cpu_ce) seen_ce = 1'b1;
        end
        check("midreset_no_ce", seen_ce, 0);
        check("midreset_mode", mode, 0);
        check("midreset_count", step_count, 0);
        reset = 1'b0;
        // Held keys are accepted again after a full debounce; old mode NORMAL so step is dropped
        k = 0;
        seen_ce = 1'b0;
        while (mode == 2'b00 && k < 40) begin
            tick();
            k++;
            if (cpu_ce) seen_ce = 1'b1;
        end
        check("held_after_reset_latency", k, 10);
        check("held_after_reset_mode", mode, 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            if (cpu_ce) seen_ce = 1'b1;
        end
        check("both_keys_no_ce", seen_ce, 0);
        check("both_keys_count", step_count, 0);
        KEY_step = 1'b1;
        KEY_mode = 1'b1;
        for (int i = 0; i < 20; i++) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
